csync_decoder: RTL and testbench

Receiver for the composite-sync/RGBI video stream the ULA emits. It samples `csync` and `r,g,b,i` on `clk14`, classifies sync pulses by width, and runs a flywheel line counter that aligns to horizontal sync. From that it produces pixel/line coordinates, a pixel strobe, single-cycle sync strobes and a lock flag. It feeds a downstream scan-doubler / frame-capture path, and on the bench it checks ULA video timing.

---
 rtl/zx_video_pkg.sv | 13 +
 rtl/csync_pulse_meter.sv | 76 +++++++
 rtl/csync_decoder.sv | 173 +++++++++++++++++
 tb/tb_csync_decoder.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/zx_video_pkg.sv
// Shared ZX video timing constants and types for the composite-sync receiver.
package zx_video_pkg;

    localparam int LINE_CLKS   = 896;
    localparam int FRAME_LINES = 320;
    localparam int WIDTH_W     = 10;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } lock_state_e;

endpackage

// File: rtl/csync_pulse_meter.sv
// Synchronises csync/colour, measures sync-low width and classifies pulses
// into registered hsync (with width) and vsync events.
module csync_pulse_meter
    import zx_video_pkg::*;
#(
    parameter int HS_MIN = 32,
    parameter int HS_MAX = 128,
    parameter int VS_MIN = 256
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               csync_i,
    input  logic [3:0]         rgbi_i,
    output logic               hs_evt_o,
    output logic [WIDTH_W-1:0] hs_width_o,
    output logic               vs_evt_o,
    output logic [3:0]         rgbi_s_o
);

    localparam logic [WIDTH_W-1:0] HS_LO = WIDTH_W'(HS_MIN);
    localparam logic [WIDTH_W-1:0] HS_HI = WIDTH_W'(HS_MAX);
    localparam logic [WIDTH_W-1:0] VS_TH = WIDTH_W'(VS_MIN);

    logic [1:0]         cs_sync_q;
    logic [3:0]         rgbi_m_q, rgbi_s_q;
    logic               cs_s, cs_d1_q;
    logic               fall, rise, hs_hit, vs_hit;
    logic [WIDTH_W-1:0] width_q, width_d;
    logic               hs_evt_q, vs_evt_q;
    logic [WIDTH_W-1:0] hs_width_q;

    assign cs_s = cs_sync_q[1];

    // Width is the count of low cycles after the falling edge, so a W-cycle
    // pulse reads W-1 on the rising edge.
    always_comb begin
        fall    = cs_d1_q & ~cs_s;
        rise    = ~cs_d1_q & cs_s;
        width_d = width_q;
        if (fall)
            width_d = '0;
        else if (!cs_s && width_q != '1)
            width_d = width_q + 1'b1;
        hs_hit  = rise && (width_q >= HS_LO) && (width_q <= HS_HI);
        vs_hit  = (width_d == VS_TH) && (width_q != VS_TH);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cs_sync_q  <= 2'b11;
            cs_d1_q    <= 1'b1;
            rgbi_m_q   <= '0;
            rgbi_s_q   <= '0;
            width_q    <= '0;
            hs_evt_q   <= 1'b0;
            hs_width_q <= '0;
            vs_evt_q   <= 1'b0;
        end else begin
            cs_sync_q  <= {cs_sync_q[0], csync_i};
            cs_d1_q    <= cs_s;
            rgbi_m_q   <= rgbi_i;
            rgbi_s_q   <= rgbi_m_q;
            width_q    <= width_d;
            hs_evt_q   <= hs_hit;
            vs_evt_q   <= vs_hit;
            if (hs_hit)
                hs_width_q <= width_q;
        end
    end

    assign hs_evt_o   = hs_evt_q;
    assign hs_width_o = hs_width_q;
    assign vs_evt_o   = vs_evt_q;
    assign rgbi_s_o   = rgbi_s_q;

endmodule

// File: rtl/csync_decoder.sv
// ULA composite-sync/RGBI receiver: flywheel line counter aligned to hsync,
// lock tracking, pixel/line coordinates and delay-matched colour.
module csync_decoder #(
    parameter int LINE_CLKS  = zx_video_pkg::LINE_CLKS,
    parameter int HS_MIN     = 32,
    parameter int HS_MAX     = 128,
    parameter int VS_MIN     = 256,
    parameter int TOL        = 4,
    parameter int LOCK_LINES = 8,
    parameter int PIX_PHASE  = 1
) (
    input  logic       clk14,
    input  logic       rst_n,
    input  logic       csync,
    input  logic       r,
    input  logic       g,
    input  logic       b,
    input  logic       i,
    output logic       hsync,
    output logic       vsync,
    output logic [8:0] x,
    output logic [8:0] y,
    output logic       pix_stb,
    output logic [3:0] rgbi,
    output logic       locked
);
    import zx_video_pkg::*;

    localparam int                 CNT_W   = $clog2(LOCK_LINES + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(LOCK_LINES - 1);
    localparam logic [9:0]         LC_LAST = 10'(LINE_CLKS - 1);
    localparam logic signed [11:0] LC_S    = 12'(LINE_CLKS);
    localparam logic signed [11:0] HALF_S  = 12'(LINE_CLKS / 2);
    localparam logic signed [11:0] TOL_S   = 12'(TOL);
    localparam logic               PIX_BIT = 1'(PIX_PHASE);

    logic               hs_evt, vs_evt;
    logic [WIDTH_W-1:0] hs_width;
    logic [3:0]         rgbi_s;

    csync_pulse_meter #(
        .HS_MIN (HS_MIN),
        .HS_MAX (HS_MAX),
        .VS_MIN (VS_MIN)
    ) u_meter (
        .clk_i      (clk14),
        .rst_ni     (rst_n),
        .csync_i    (csync),
        .rgbi_i     ({g, r, b, i}),
        .hs_evt_o   (hs_evt),
        .hs_width_o (hs_width),
        .vs_evt_o   (vs_evt),
        .rgbi_s_o   (rgbi_s)
    );

    lock_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       miss_q, miss_d;
    logic [9:0]       lc_q, lc_d;
    logic [8:0]       y_q, y_d;
    logic             hsync_q, vsync_q, vsync_d, pix_stb_q;
    logic [3:0]       rgbi_q;
    logic             in_vsync_q, in_vsync_d, hs_seen_q, hs_seen_d;
    logic signed [11:0] diff, err;
    logic             good, wrap, realign, miss_inc;

    // Phase error of the sync against the flywheel, folded into one line.
    always_comb begin
        diff = $signed({2'b00, lc_q}) - $signed({2'b00, hs_width}) - 12'sd1;
        err  = diff;
        if (diff > HALF_S)
            err = diff - LC_S;
        else if (diff <= -HALF_S)
            err = diff + LC_S;
        good = (err <= TOL_S) && (err >= -TOL_S);
    end

    always_comb begin
        wrap       = (lc_q == LC_LAST);
        realign    = hs_evt && ((state_q == HUNT) || good);
        lc_d       = realign ? 10'(hs_width + 10'd2) : (wrap ? 10'd0 : lc_q + 1'b1);
        vsync_d    = vs_evt && !in_vsync_q;
        y_d        = y_q;
        if (vsync_d)
            y_d = '0;
        else if (wrap && y_q != '1)
            y_d = y_q + 1'b1;
        in_vsync_d = hs_evt ? 1'b0 : (vs_evt ? 1'b1 : in_vsync_q);
        hs_seen_d  = hs_evt ? 1'b1 : (wrap ? 1'b0 : hs_seen_q);
        miss_inc   = (hs_evt && !good) ||
                     (wrap && !hs_seen_q && !hs_evt && !in_vsync_q);
    end

    always_ff @(posedge clk14) begin
        if (!rst_n)
            state_q <= HUNT;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        miss_d  = miss_q;
        case (state_q)
            HUNT: begin
                if (hs_evt) begin
                    if (!good) begin
                        cnt_d = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = LOCKED;
                        cnt_d   = '0;
                        miss_d  = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            LOCKED: begin
                if (hs_evt && good) begin
                    miss_d = '0;
                end else if (miss_inc) begin
                    if (miss_q == 2'd1) begin
                        state_d = HUNT;
                        cnt_d   = '0;
                        miss_d  = '0;
                    end else begin
                        miss_d = miss_q + 1'b1;
                    end
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_comb begin
        locked = (state_q == LOCKED);
    end

    always_ff @(posedge clk14) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            miss_q     <= '0;
            lc_q       <= '0;
            y_q        <= '0;
            hsync_q    <= 1'b0;
            vsync_q    <= 1'b0;
            pix_stb_q  <= 1'b0;
            rgbi_q     <= '0;
            in_vsync_q <= 1'b0;
            hs_seen_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            miss_q     <= miss_d;
            lc_q       <= lc_d;
            y_q        <= y_d;
            hsync_q    <= wrap;
            vsync_q    <= vsync_d;
            pix_stb_q  <= (lc_d[0] == PIX_BIT);
            rgbi_q     <= rgbi_s;
            in_vsync_q <= in_vsync_d;
            hs_seen_q  <= hs_seen_d;
        end
    end

    assign hsync   = hsync_q;
    assign vsync   = vsync_q;
    assign x       = lc_q[9:1];
    assign y       = y_q;
    assign pix_stb = pix_stb_q;
    assign rgbi    = rgbi_q;

endmodule

// File: tb/tb_csync_decoder.sv
// Directed bench for csync_decoder: lock, colour alignment, glitches, vsync,
// phase step, signal loss and mid-frame reset.
module tb_csync_decoder;

    localparam int LINE = 896;

    logic       clk14 = 1'b0;
    logic       rst_n = 1'b0;
    logic       csync = 1'b1;
    logic       r = 1'b0, g = 1'b0, b = 1'b0, i = 1'b0;
    logic       hsync, vsync, pix_stb, locked;
    logic [8:0] x, y;
    logic [3:0] rgbi;

    int errs = 0;
    int checks = 0;
    int cyc = 0;
    int hs_cnt, vs_cnt, nz_cnt, vs_stamp, vs_first;
    int p_hs, p_vs, p_x, p_y, p_pix, p_rgbi, p_lock;

    csync_decoder dut (
        .clk14   (clk14),
        .rst_n   (rst_n),
        .csync   (csync),
        .r       (r),
        .g       (g),
        .b       (b),
        .i       (i),
        .hsync   (hsync),
        .vsync   (vsync),
        .x       (x),
        .y       (y),
        .pix_stb (pix_stb),
        .rgbi    (rgbi),
        .locked  (locked)
    );

    always #5 clk14 = ~clk14;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // One video line: sync low at [off, off+w), optional glitch, one coloured
    // pixel, optional 1-cycle reset, and a snapshot of outputs at probe_c.
    task automatic run_line(input int off, input int w, input int goff, input int gw,
                            input int pix_c, input int rst_c, input int probe_c);
        hs_cnt = 0;
        vs_cnt = 0;
        nz_cnt = 0;
        for (int c = 0; c < LINE; c++) begin
            csync = !((c >= off && c < off + w) || (c >= goff && c < goff + gw));
            {g, r, b, i} = (c == pix_c) ? 4'b1010 : 4'b0000;
            rst_n = (c != rst_c);
            @(posedge clk14);
            #1;
            cyc++;
            if (hsync) hs_cnt++;
            if (vsync) begin
                vs_cnt++;
                vs_stamp = cyc;
            end
            if (rgbi != 4'd0) nz_cnt++;
            if (c == probe_c) begin
                p_hs = int'(hsync);  p_vs = int'(vsync);   p_x = int'(x);
                p_y = int'(y);       p_pix = int'(pix_stb); p_rgbi = int'(rgbi);
                p_lock = int'(locked);
            end
        end
    endtask

    initial begin
        repeat (3) begin
            @(posedge clk14);
            #1;
            cyc++;
        end
        chk("rst_hsync", hsync, 0);
        chk("rst_vsync", vsync, 0);
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_pix", pix_stb, 0);
        chk("rst_rgbi", rgbi, 0);
        chk("rst_locked", locked, 0);
        rst_n = 1'b1;

        // Ideal lines: lock on the 8th hsync, lc=0 two cycles after the edge.
        run_line(0, 64, -1, 0, -1, -1, -1);
        run_line(0, 64, -1, 0, -1, -1, 2);
        chk("l1_hsync_at_0", p_hs, 1);
        chk("l1_x_at_0", p_x, 0);
        chk("l1_hs_count", hs_cnt, 1);
        for (int n = 2; n < 7; n++) run_line(0, 64, -1, 0, -1, -1, -1);
        chk("lock_before_8th", locked, 0);
        run_line(0, 64, -1, 0, -1, -1, -1);
        chk("lock_on_8th", locked, 1);
        chk("y_after_7_wraps", y, 7);

        // Single coloured pixel shows up three cycles on, on a strobe cycle.
        run_line(0, 64, -1, 0, 301, -1, 303);
        chk("pix_rgbi", p_rgbi, 4'b1010);
        chk("pix_stb", p_pix, 1);
        chk("pix_x", p_x, 150);
        chk("pix_single", nz_cnt, 1);

        // Short glitch mid-line leaves the flywheel alone.
        run_line(0, 64, 400, 10, -1, -1, 600);
        chk("glitch_x", p_x, 299);
        chk("glitch_locked", p_lock, 1);
        chk("glitch_hs_count", hs_cnt, 1);
        chk("glitch_y", y, 9);

        // Two short frames of 12 lines separated by long vsync pulses.
        run_line(0, 300, -1, 0, -1, -1, -1);
        chk("vs1_count", vs_cnt, 1);
        chk("vs1_y", y, 0);
        vs_first = vs_stamp;
        for (int n = 0; n < 11; n++) run_line(0, 64, -1, 0, -1, -1, -1);
        chk("y_before_vs", y, 11);
        run_line(0, 300, -1, 0, -1, -1, -1);
        chk("vs2_count", vs_cnt, 1);
        chk("vs_period", vs_stamp - vs_first, 12 * LINE);
        chk("vs2_y", y, 0);
        run_line(0, 64, -1, 0, -1, -1, -1);
        chk("vs_locked", locked, 1);

        // Phase step of +10 cycles.
        run_line(10, 64, -1, 0, -1, -1, -1);
        chk("step_bad1_locked", locked, 1);
        run_line(10, 64, -1, 0, -1, -1, -1);
        chk("step_bad2_unlocked", locked, 0);
        for (int n = 2; n < 10; n++) run_line(10, 64, -1, 0, -1, -1, -1);
        chk("step_relock_early", locked, 0);
        run_line(10, 64, -1, 0, -1, -1, -1);
        chk("step_relock", locked, 1);
        run_line(10, 64, -1, 0, -1, -1, 12);
        chk("step_x0", p_x, 0);
        chk("step_hsync", p_hs, 1);

        // Signal loss: three empty lines, flywheel keeps running.
        run_line(10, 0, -1, 0, -1, -1, -1);
        chk("loss0_hs", hs_cnt, 1);
        run_line(10, 0, -1, 0, -1, -1, 12);
        chk("loss1_hs", hs_cnt, 1);
        chk("loss1_locked", p_lock, 1);
        run_line(10, 0, -1, 0, -1, -1, 12);
        chk("loss2_hs", hs_cnt, 1);
        chk("loss2_hsync", p_hs, 1);
        chk("loss2_unlocked", p_lock, 0);

        // One-cycle reset on the line-start cycle, then relock.
        run_line(10, 64, -1, 0, -1, 12, 12);
        chk("mid_rst_hsync", p_hs, 0);
        chk("mid_rst_vsync", p_vs, 0);
        chk("mid_rst_x", p_x, 0);
        chk("mid_rst_y", p_y, 0);
        chk("mid_rst_pix", p_pix, 0);
        chk("mid_rst_rgbi", p_rgbi, 0);
        chk("mid_rst_locked", p_lock, 0);
        for (int n = 1; n < 7; n++) run_line(10, 64, -1, 0, -1, -1, -1);
        chk("mid_rst_lock_early", locked, 0);
        run_line(10, 64, -1, 0, -1, -1, -1);
        chk("mid_rst_relock", locked, 1);
        chk("mid_rst_y_count", y, 7);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
